// File: rtl/servo_pkg.sv
// Shared servo types: FSM state codes, packed 4-joint angle vector, angle defaults.
// Used by the move sequencer and the PWM / angle-decode blocks.
package servo_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LATCH  = 3'd1;
    localparam state_t ST_RAMP   = 3'd2;
    localparam state_t ST_SETTLE = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // Index 0 is joint 1, matching the {j4,j3,j2,j1} bus packing.
    typedef logic [3:0][7:0] angles_t;

    localparam int HOME_ANGLE_DEF = 90;
    localparam int MAX_ANGLE_DEF  = 180;

    function automatic logic [7:0] clamp_angle(input logic [7:0] a, input logic [7:0] lim);
        return (a > lim) ? lim : a;
    endfunction

endpackage

// File: rtl/slew_step.sv
// One joint's slew step toward its target, never overshooting.
// Purely combinational; the difference is formed before stepping so 8-bit math cannot wrap.
module slew_step #(
    parameter int STEP = 1
) (
    input  logic [7:0] cur,
    input  logic [7:0] tgt,
    output logic [7:0] nxt,
    output logic       at_target
);

    logic [7:0] diff;
    logic [7:0] mv;

    always_comb begin
        diff      = (tgt > cur) ? (tgt - cur) : (cur - tgt);
        mv        = (diff < 8'(STEP)) ? diff : 8'(STEP);
        nxt       = (tgt > cur) ? (cur + mv) : (cur - mv);
        at_target = (cur == tgt);
    end

endmodule

// File: rtl/servo_move_sequencer.sv
// Arbitrates auto/manual move requests, slew-limits the 4-joint arm, pulses move_complete.
// Latency: grant 1 cycle after the request is seen in IDLE; done (max_delta/STEP+SETTLE_TICKS)*TICK_DIV+3 cycles after it.
// Backpressure: requests are levels held until their gnt pulse; MANUAL_PREEMPT_EN lets manual abort an auto move.
module servo_move_sequencer
    import servo_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int STEP         = 1,
    parameter int SETTLE_TICKS = 20,
    parameter int MAX_ANGLE    = MAX_ANGLE_DEF,
    parameter int HOME_ANGLE   = HOME_ANGLE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        auto_req,
    input  logic [31:0] auto_angles,
    output logic        auto_gnt,
    input  logic        man_req,
    input  logic [31:0] man_angles,
    output logic        man_gnt,
    output logic [7:0]  angle1,
    output logic [7:0]  angle2,
    output logic [7:0]  angle3,
    output logic [7:0]  angle4,
    output logic        busy,
    output logic        active_src,
`ifdef MANUAL_PREEMPT_EN
    output logic        auto_abort,
`endif
    output logic        move_complete
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

    state_t          state;
    angles_t         cur;
    angles_t         tgt;
    angles_t         nxt;
    angles_t         req_ang;
    angles_t         clamped;
    logic [3:0]      at_tgt;
    logic [TW-1:0]   tick_cnt;
    logic [SW-1:0]   settle_cnt;
    logic            tick_wrap;
    logic            preempt;

    always_comb begin
        req_ang = active_src ? angles_t'(man_angles) : angles_t'(auto_angles);
        for (int j = 0; j < 4; j++) begin
            clamped[j] = clamp_angle(req_ang[j], 8'(MAX_ANGLE));
        end
    end

    for (genvar j = 0; j < 4; j++) begin : g_joint
        slew_step #(.STEP(STEP)) u_step (
            .cur       (cur[j]),
            .tgt       (tgt[j]),
            .nxt       (nxt[j]),
            .at_target (at_tgt[j])
        );
    end

    assign tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));

`ifdef MANUAL_PREEMPT_EN
    logic abort_q;
    assign preempt    = man_req && !active_src && ((state == ST_RAMP) || (state == ST_SETTLE));
    assign auto_abort = abort_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= preempt;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            active_src <= 1'b0;
            cur        <= {4{8'(HOME_ANGLE)}};
            tgt        <= {4{8'(HOME_ANGLE)}};
            tick_cnt   <= '0;
            settle_cnt <= '0;
        end else if (preempt) begin
            // Joints stay where they are; they become the start point of the manual ramp.
            state      <= ST_LATCH;
            active_src <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (man_req) begin
                        state      <= ST_LATCH;
                        active_src <= 1'b1;
                    end else if (auto_req) begin
                        state      <= ST_LATCH;
                        active_src <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    tgt      <= clamped;
                    tick_cnt <= '0;
                    state    <= ST_RAMP;
                end
                ST_RAMP: begin
                    if (&at_tgt) begin
                        state      <= ST_SETTLE;
                        tick_cnt   <= '0;
                        settle_cnt <= '0;
                    end else if (tick_wrap) begin
                        tick_cnt <= '0;
                        cur      <= nxt;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (SETTLE_TICKS == 0) begin
                        state <= ST_DONE;
                    end else if (tick_wrap) begin
                        tick_cnt <= '0;
                        if (settle_cnt == SW'(SETTLE_TICKS - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign auto_gnt      = (state == ST_LATCH) && !active_src;
    assign man_gnt       = (state == ST_LATCH) && active_src;
    assign busy          = (state != ST_IDLE);
    assign move_complete = (state == ST_DONE);

    assign angle1 = cur[0];
    assign angle2 = cur[1];
    assign angle3 = cur[2];
    assign angle4 = cur[3];

endmodule

// File: tb/tb_servo_move_sequencer.sv
// Directed bench for servo_move_sequencer with TICK_DIV=4, STEP=1, SETTLE_TICKS=2.
// Cycle numbers count posedges after the request is driven; the first such edge is cycle 1.
module tb_servo_move_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        auto_req = 1'b0;
    logic [31:0] auto_angles = '0;
    logic        auto_gnt;
    logic        man_req = 1'b0;
    logic [31:0] man_angles = '0;
    logic        man_gnt;
    logic [7:0]  angle1, angle2, angle3, angle4;
    logic        busy;
    logic        active_src;
    logic        move_complete;
`ifdef MANUAL_PREEMPT_EN
    logic        auto_abort;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    servo_move_sequencer #(
        .TICK_DIV     (4),
        .STEP         (1),
        .SETTLE_TICKS (2),
        .MAX_ANGLE    (180),
        .HOME_ANGLE   (90)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .auto_req      (auto_req),
        .auto_angles   (auto_angles),
        .auto_gnt      (auto_gnt),
        .man_req       (man_req),
        .man_angles    (man_angles),
        .man_gnt       (man_gnt),
        .angle1        (angle1),
        .angle2        (angle2),
        .angle3        (angle3),
        .angle4        (angle4),
        .busy          (busy),
        .active_src    (active_src),
`ifdef MANUAL_PREEMPT_EN
        .auto_abort    (auto_abort),
`endif
        .move_complete (move_complete)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int j4, input int j3, input int j2, input int j1);
        return {8'(j4), 8'(j3), 8'(j2), 8'(j1)};
    endfunction

    function automatic logic [31:0] cur_angles();
        return {angle4, angle3, angle2, angle1};
    endfunction

    // Drives one request, drops it at its grant, waits for move_complete, returns to IDLE.
    task automatic do_move(input bit man, input logic [31:0] ang,
                           output int gnt_cyc, output int gnt_cnt,
                           output int mc_cyc, output int src_at_mc);
        gnt_cyc = -1; gnt_cnt = 0; mc_cyc = -1; src_at_mc = -1;
        @(negedge clk);
        if (man) begin man_angles = ang; man_req = 1'b1; end
        else     begin auto_angles = ang; auto_req = 1'b1; end
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk); #1;
            if ((man && man_gnt) || (!man && auto_gnt)) begin
                gnt_cnt++;
                if (gnt_cyc < 0) gnt_cyc = c;
                man_req = 1'b0; auto_req = 1'b0;
            end
            if (move_complete) begin
                mc_cyc = c;
                src_at_mc = int'(active_src);
                break;
            end
        end
        man_req = 1'b0; auto_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int g, gc, mc, src;
        int mgc, agc, mc1, mc2, mcn, ag_early;

        // Reset state
        #12;
        chk("reset_angles", cur_angles(), pack(90, 90, 90, 90));
        chk("reset_busy", busy, 0);
        chk("reset_mc", move_complete, 0);
        chk("reset_gnts", {auto_gnt, man_gnt}, 0);
        chk("reset_src", active_src, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // Basic auto move: max delta 10 -> done at (10+2)*4+3
        do_move(1'b0, pack(100, 90, 80, 95), g, gc, mc, src);
        chk("a_gnt_cycle", g, 1);
        chk("a_gnt_pulses", gc, 1);
        chk("a_mc_cycle", mc, 51);
        chk("a_src", src, 0);
        chk("a_angles", cur_angles(), pack(100, 90, 80, 95));
        chk("a_idle", busy, 0);

        // Simultaneous requests: manual first, auto right after it completes
        mgc = -1; agc = -1; mc1 = -1; mc2 = -1; mcn = 0; ag_early = 0;
        @(negedge clk);
        man_angles  = pack(100, 90, 80, 100);
        auto_angles = pack(90, 90, 90, 90);
        man_req = 1'b1; auto_req = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (man_gnt && mgc < 0) begin
                mgc = c; man_req = 1'b0;
                chk("s_src_man", active_src, 1);
            end
            if (auto_gnt) begin
                if (mcn == 0) ag_early++;
                if (agc < 0) agc = c;
                auto_req = 1'b0;
            end
            if (move_complete) begin
                mcn++;
                if (mcn == 1) mc1 = c; else mc2 = c;
            end
            if (mcn == 2) break;
        end
        man_req = 1'b0; auto_req = 1'b0;
        @(posedge clk); #1;
        chk("s_man_gnt_cycle", mgc, 1);
        chk("s_no_early_auto", ag_early, 0);
        chk("s_man_mc_cycle", mc1, 31);
        chk("s_auto_gnt_cycle", agc, 33);
        chk("s_auto_mc_cycle", mc2, 83);
        chk("s_src_auto", active_src, 0);
        chk("s_angles", cur_angles(), pack(90, 90, 90, 90));

        // Clamp: 200 on j1 stops at 180
        do_move(1'b0, pack(90, 90, 90, 200), g, gc, mc, src);
        chk("c_angle1", angle1, 180);
        chk("c_mc_cycle", mc, 371);

        // Targets equal to current angles: settle only
        do_move(1'b0, pack(90, 90, 90, 180), g, gc, mc, src);
        chk("z_mc_cycle", mc, 11);
        chk("z_angles", cur_angles(), pack(90, 90, 90, 180));

        // Reset in the middle of a ramp from 180 down to 90
        mcn = 0;
        @(negedge clk);
        auto_angles = pack(90, 90, 90, 90); auto_req = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk); #1;
            if (auto_gnt) auto_req = 1'b0;
            if (move_complete) mcn++;
            if (angle1 == 8'd95) break;
        end
        chk("r_reached_95", angle1, 95);
        rst = 1'b0; #1;
        chk("r_async_angles", cur_angles(), pack(90, 90, 90, 90));
        chk("r_busy", busy, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (move_complete || busy) mcn++;
        end
        chk("r_no_complete", mcn, 0);
        chk("r_angles_after", cur_angles(), pack(90, 90, 90, 90));

`ifdef MANUAL_PREEMPT_EN
        begin
            int ab, mcount, srcv, mg;
            ab = 0; mcount = 0; srcv = -1; mg = 0;
            @(negedge clk);
            auto_angles = pack(90, 90, 90, 150); auto_req = 1'b1;
            for (int c = 1; c <= 800; c++) begin
                @(posedge clk); #1;
                if (auto_gnt) auto_req = 1'b0;
                if (auto_abort) begin
                    ab++;
                    chk("p_angle_at_abort", angle1, 120);
                end
                if (man_gnt) begin mg++; man_req = 1'b0; end
                if (move_complete) begin mcount++; srcv = int'(active_src); end
                if (angle1 == 8'd120 && mg == 0 && ab == 0) begin
                    man_angles = pack(90, 90, 90, 60); man_req = 1'b1;
                end
                if (mcount == 1) break;
            end
            man_req = 1'b0; auto_req = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (move_complete) mcount++;
            end
            chk("p_abort_pulses", ab, 1);
            chk("p_man_gnt", mg, 1);
            chk("p_complete_count", mcount, 1);
            chk("p_src", srcv, 1);
            chk("p_angle1", angle1, 60);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/servo_move_sequencer.md
Name: servo_move_sequencer

Overview:
- Motion controller between the path-planning requester (Q-learning step output) and the PWM servo stage.
- Arbitrates two requesters, automatic (planner) and manual (switch jog), for the single 4-servo arm.
- Latches the granted 4-joint target set and slew-limits each joint toward its target, one step per tick.
- After a settle period, pulses move_complete. This pulse is the handshake that advances the planner to its next state.

Parameters:
- TICK_DIV, 50000, clk cycles per slew tick (1 ms at 50 MHz); minimum 2.
- STEP, 1, degrees moved per joint per tick.
- SETTLE_TICKS, 20, ticks to hold after all joints reach target before completing.
- MAX_ANGLE, 180, upper clamp on any target angle.
- HOME_ANGLE, 90, reset value of every joint.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- auto_req  in  1  planner move request; level, held until auto_gnt.
- auto_angles  in  32  planner targets, packed {j4,j3,j2,j1}, 8 bits each.
- auto_gnt  out  1  one-cycle pulse: auto targets latched.
- man_req  in  1  manual move request; level, held until man_gnt.
- man_angles  in  32  manual targets, same packing.
- man_gnt  out  1  one-cycle pulse: manual targets latched.
- angle1..angle4  out  8 each  current commanded joint angles, to the PWM stage.
- busy  out  1  high in every state except IDLE.
- active_src  out  1  0 = auto, 1 = manual; source of the current/last move.
- move_complete  out  1  one-cycle pulse at the end of a move.

Behaviour:
- Reset (async, rst=0): state IDLE, angle1..4=HOME_ANGLE, gnt/move_complete/busy=0, active_src=0, tick and settle counters=0.
- FSM states: IDLE -> LATCH -> RAMP -> SETTLE -> DONE -> IDLE.
- IDLE:
  - If man_req=1, grant manual. Else if auto_req=1, grant auto. Manual wins a simultaneous request.
  - Arbitration is sampled only in IDLE. A request arriving during a move waits.
- LATCH (1 cycle):
  - Assert the matching gnt pulse and set active_src.
  - Latch targets, clamping each to min(target, MAX_ANGLE).
  - Clear the tick counter.
- RAMP:
  - Tick counter counts 0..TICK_DIV-1; a tick fires on wrap.
  - On each tick, every joint with angle!=target moves toward the target by min(STEP, |target-angle|). There is no overshoot, and all joints move concurrently.
  - Arithmetic is 8-bit unsigned; the difference is computed before stepping, so there is no underflow at 0.
  - Exit to SETTLE on the cycle where all four joints equal their targets, checked combinationally after the update.
  - If the targets already equal the current angles, leave RAMP on the first cycle (zero ticks of motion).
- SETTLE: count SETTLE_TICKS ticks (tick counter reused, cleared on entry). Angles are held. SETTLE_TICKS=0 passes straight to DONE.
- DONE (1 cycle): move_complete=1, then IDLE.
- Latency: a request seen in IDLE is granted on the next cycle. move_complete follows after (max joint delta/STEP + SETTLE_TICKS)*TICK_DIV + 3 cycles.
- Requester changes:
  - Requester inputs are ignored after LATCH; targets are held in internal registers.
  - Dropping a req before its grant cancels it with no side effect.
- Reset mid-move: angles snap to HOME_ANGLE immediately. No move_complete is issued.

Optional Feature:
- Macro MANUAL_PREEMPT_EN.
- Defined:
  - man_req=1 while state is RAMP or SETTLE and active_src=0 aborts the auto move.
  - FSM goes to LATCH for the manual request; joints keep their current positions as the ramp start.
  - The aborted auto move never gets move_complete.
  - An extra output auto_abort (1 bit) pulses for 1 cycle at the abort.
- Undefined: manual requests wait for IDLE as above. The auto_abort port does not exist.

Decomposition:
- Shared package servo_pkg holds:
  - the state enum;
  - typedef angles_t (packed array [4] of 8-bit);
  - HOME/MAX defaults, shared with the PWM and angle-decode blocks.
- One sub-module, slew_step: combinational per-joint step of (cur, tgt, STEP) -> (next, at_target), instantiated 4 times.

Test Plan:
- All tests use TICK_DIV=4, STEP=1, SETTLE_TICKS=2.
- Reset release: angle1..4=90, busy=0. Then auto_req with {100,90,80,95} -> auto_gnt 1 cycle later. Joints reach targets after 10 ticks; move_complete 1 pulse at (10+2)*4+3 cycles.
- Simultaneous auto_req and man_req in IDLE -> man_gnt only, active_src=1. auto_gnt follows after that move's move_complete.
- Target 200 on j1 -> clamped; angle1 stops at 180. Targets equal to current angles -> move_complete after 2*4+3 cycles with no angle change.
- Assert rst=0 mid-RAMP with angle1=95 -> all angles 90 asynchronously, no move_complete, state IDLE.
- MANUAL_PREEMPT_EN: auto move to j1=150 interrupted by man_req {j1=60} at angle1=120 -> auto_abort pulse, man_gnt. angle1 ramps down from 120 to 60, single move_complete with active_src=1.
